fft16_input_loader: RTL and testbench
=====================================

Name: fft16_input_loader

Overview:
- Upstream feeder for the 16-point radix-2 FFT datapath.
- Accepts a serial stream of complex samples over a valid/ready handshake and assembles them into 16-sample frames in a ping-pong (two-bank) buffer.
- Presents one complete frame as 32 parallel words (X0r/X0i .. X15r/X15i, natural order) that stay stable until the downstream stage acknowledges the frame.
- Lets the next frame load while the FFT consumes the current one.

Parameters:
- N, 16, bit width of each real and each imaginary sample word (two's complement); matches the FFT's N.
- PTS, 16, frame length in complex samples; fixed at 16, and any other value is unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  input sample valid.
- s_ready  output  1  loader can accept a sample this cycle.
- s_re  input  N  real part of the input sample.
- s_im  input  N  imaginary part of the input sample.
- f_valid  output  1  complete frame present on f_re/f_im.
- f_ready  input  1  downstream consumes the frame.
- f_re  output  16*N  frame real parts; sample k at [k*N +: N], k=0 is the first sample received.
- f_im  output  16*N  frame imaginary parts; same packing as f_re.
- wr_idx  output  4  index of the next sample slot in the write bank.
- frame_cnt  output  8  count of frames handed off; wraps at 255->0.

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - f_valid=0, wr_idx=0, frame_cnt=0, both banks marked empty, write pointer=bank0, read pointer=bank0.
  - s_ready=1 from the first cycle after reset is released.
  - f_re/f_im=0.
  - Bank storage contents need not be cleared, but the f_re/f_im outputs must read 0 while f_valid=0 after reset.
- Accept:
  - A sample is accepted on a rising edge with s_valid & s_ready.
  - It is written to slot wr_idx of the write bank, and wr_idx increments.
  - s_valid with s_ready=0 has no effect; the source holds its data.
- Frame completion:
  - Accepting slot 15 marks the write bank full, wraps wr_idx to 0 and toggles the write pointer.
- s_ready = the bank addressed by the write pointer is not full. It is a combinational function of registered state only; no combinational path from s_valid or f_ready.
- Read side:
  - f_valid = the bank addressed by the read pointer is full.
  - f_re/f_im are driven from that bank.
  - Latency: f_valid rises the cycle after slot 15 is accepted, provided that bank is the read bank.
- Hand-off:
  - f_valid & f_ready at an edge marks the read bank empty, toggles the read pointer and increments frame_cnt.
  - f_re/f_im must not change while f_valid=1 and f_ready=0.
- States per bank: EMPTY -> FILLING (first accept) -> FULL (slot 15 accepted) -> EMPTY (hand-off).
  - At most one bank is FILLING at a time.
- Both banks full: s_ready=0 and input stalls.
  - A hand-off in that cycle frees a bank, so s_ready=1 on the next cycle.
- Simultaneous events in one cycle are legal and must both take effect:
  - slot-15 accept into one bank together with hand-off of the other bank. Afterwards the newly full bank becomes the read bank (f_valid stays 1 with new data) and the freed bank becomes the write bank.
- Back-to-back streaming: with f_ready held 1 and s_valid held 1, throughput is 1 sample/cycle with no bubbles, and one frame every 16 cycles.
- Reset mid-frame: the partial frame is discarded and a held frame is dropped (f_valid=0). No frame_cnt increment.
- No arithmetic is done on the data. Samples pass bit-exact; sign extension is the FFT's job.

Test Plan:
- Reset, then feed s_re=k, s_im=-k for k=0..15 continuously with f_ready=0 -> f_valid rises one cycle after the 16th accept; f_re[k*N +: N]=k and f_im[k*N +: N]=-k; wr_idx=0; s_ready stays 1.
- Continue 16 more samples (100+k) with f_ready=0, then one more attempt -> both banks full. s_ready=0 from the cycle after the 32nd accept. f_re still shows 0..15 (frame 1 held). The 33rd sample is not accepted.
- Pulse f_ready for one cycle in that state -> frame_cnt=1; f_re shows 100..115 next cycle; s_ready=1; the 33rd sample is then accepted into slot 0.
- Stream 64 samples with s_valid=1 and f_ready=1 -> exactly 4 f_valid handshakes, spaced 16 cycles apart; frame_cnt=4; s_ready never drops; each frame's data is bit-exact, including extremes 0x8000 and 0x7FFF.
- Assert rst after 7 samples of a frame while another frame is held -> next cycle f_valid=0, wr_idx=0, frame_cnt=0. The next 16 samples form frame 0 correctly, with no leftover samples.
- Align the 16th accept with f_ready=1 on a held frame -> same-cycle swap. f_valid stays 1 with the new frame, frame_cnt increments by exactly 1, and no sample is lost or duplicated.

Source files
------------

// File: rtl/fft16_input_loader.sv
// ---------------------------------------------------------------------------
// fft16_input_loader
//
// Upstream feeder for the 16-point radix-2 FFT datapath. Serial complex
// samples arrive over a valid/ready handshake and are collected into 16-sample
// frames in a two-bank (ping-pong) buffer. One complete frame is presented as
// 16 parallel complex words, in natural order, and held stable until the
// downstream stage takes it. The other bank keeps loading in the meantime.
//
// Parameters
//   N    width of each real / imaginary sample word (two's complement)
//   PTS  frame length in complex samples; only 16 is supported
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   s_valid    input sample valid
//   s_ready    loader can accept a sample this cycle
//   s_re/s_im  input sample, real / imaginary
//   f_valid    a complete frame is present on f_re / f_im
//   f_ready    downstream takes the frame at this edge
//   f_re/f_im  frame words, sample k at [k*N +: N], k=0 received first
//   wr_idx     next slot to be written in the write bank
//   frame_cnt  number of frames handed off, wraps 255 -> 0
// ---------------------------------------------------------------------------
module fft16_input_loader #(
   parameter int N   = 16,
   parameter int PTS = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [N-1:0]    s_re,
   input  logic [N-1:0]    s_im,
   output logic            f_valid,
   input  logic            f_ready,
   output logic [16*N-1:0] f_re,
   output logic [16*N-1:0] f_im,
   output logic [3:0]      wr_idx,
   output logic [7:0]      frame_cnt
);

   localparam int IDX_LAST = PTS - 1;

   // Per-bank life cycle: EMPTY -> FILLING -> FULL -> EMPTY
   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_t;

   bank_state_t       bank_state_r      [2];
   bank_state_t       bank_state_next_s [2];

   logic              wr_ptr_r;
   logic              rd_ptr_r;
   logic [3:0]        wr_idx_r;
   logic [7:0]        frame_cnt_r;

   // Sample storage; contents are not reset, the output mux hides them.
   logic [N-1:0]      mem_re_r [2][PTS];
   logic [N-1:0]      mem_im_r [2][PTS];

   logic              s_ready_s;
   logic              f_valid_s;
   logic              accept_s;
   logic              handoff_s;
   logic              last_slot_s;
   logic [16*N-1:0]   f_re_s;
   logic [16*N-1:0]   f_im_s;

   // Handshake decode; ready/valid depend on registered bank state only
   always_comb begin
      s_ready_s   = (bank_state_r[wr_ptr_r] != BANK_FULL);
      f_valid_s   = (bank_state_r[rd_ptr_r] == BANK_FULL);
      accept_s    = s_valid & s_ready_s;
      handoff_s   = f_valid_s & f_ready;
      last_slot_s = (wr_idx_r == 4'(IDX_LAST));
   end

   // Bank next-state: write side fills the write bank, read side empties the read bank
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         bank_state_next_s[b] = bank_state_r[b];
         case (bank_state_r[b])
            BANK_EMPTY: begin
               if (accept_s && (wr_ptr_r == 1'(b))) begin
                  if (last_slot_s) begin
                     bank_state_next_s[b] = BANK_FULL;
                  end else begin
                     bank_state_next_s[b] = BANK_FILLING;
                  end
               end else begin
                  bank_state_next_s[b] = BANK_EMPTY;
               end
            end
            BANK_FILLING: begin
               if (accept_s && (wr_ptr_r == 1'(b)) && last_slot_s) begin
                  bank_state_next_s[b] = BANK_FULL;
               end else begin
                  bank_state_next_s[b] = BANK_FILLING;
               end
            end
            BANK_FULL: begin
               // A full bank is never the target of a write (s_ready is low
               // while the write pointer addresses it), so only hand-off leaves.
               if (handoff_s && (rd_ptr_r == 1'(b))) begin
                  bank_state_next_s[b] = BANK_EMPTY;
               end else begin
                  bank_state_next_s[b] = BANK_FULL;
               end
            end
            default: begin
               bank_state_next_s[b] = BANK_EMPTY;
            end
         endcase
      end
   end

   // Bank state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_state_r[0] <= BANK_EMPTY;
         bank_state_r[1] <= BANK_EMPTY;
      end else begin
         bank_state_r[0] <= bank_state_next_s[0];
         bank_state_r[1] <= bank_state_next_s[1];
      end
   end

   // Write slot index, bank pointers and hand-off counter
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx_r    <= 4'd0;
         wr_ptr_r    <= 1'b0;
         rd_ptr_r    <= 1'b0;
         frame_cnt_r <= 8'd0;
      end else begin
         if (accept_s) begin
            if (last_slot_s) begin
               wr_idx_r <= 4'd0;
               wr_ptr_r <= ~wr_ptr_r;
            end else begin
               wr_idx_r <= wr_idx_r + 4'd1;
            end
         end
         // Independent of the write side: a slot-15 accept into one bank and a
         // hand-off of the other bank may land on the same edge.
         if (handoff_s) begin
            rd_ptr_r    <= ~rd_ptr_r;
            frame_cnt_r <= frame_cnt_r + 8'd1;
         end
      end
   end

   // Sample storage write; data passes bit-exact
   always_ff @(posedge clk) begin
      if (accept_s && !rst) begin
         mem_re_r[wr_ptr_r][wr_idx_r] <= s_re;
         mem_im_r[wr_ptr_r][wr_idx_r] <= s_im;
      end
   end

   // Frame output mux; forced to zero while no complete frame is presented so
   // uninitialised storage never reaches the FFT after reset.
   always_comb begin
      f_re_s = '0;
      f_im_s = '0;
      if (f_valid_s) begin
         for (int k = 0; k < PTS; k++) begin
            f_re_s[k*N +: N] = mem_re_r[rd_ptr_r][k];
            f_im_s[k*N +: N] = mem_im_r[rd_ptr_r][k];
         end
      end else begin
         f_re_s = '0;
         f_im_s = '0;
      end
   end

   assign s_ready   = s_ready_s;
   assign f_valid   = f_valid_s;
   assign f_re      = f_re_s;
   assign f_im      = f_im_s;
   assign wr_idx    = wr_idx_r;
   assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_fft16_input_loader.sv
// ---------------------------------------------------------------------------
// tb_fft16_input_loader
//
// Self-checking bench for fft16_input_loader. Frames are described by a table
// of {base, step, expected frame_cnt} records. Every accepted sample (seen as
// s_valid & s_ready before an edge) is assembled into an expected frame that
// is queued; every f_valid & f_ready hand-off pops the oldest expected frame
// and compares it with f_re / f_im. Directed sequences cover back-pressure,
// reset mid-frame and the same-cycle swap.
// ---------------------------------------------------------------------------
module tb_fft16_input_loader;

   localparam int N = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            s_valid;
   logic            s_ready;
   logic [N-1:0]    s_re;
   logic [N-1:0]    s_im;
   logic            f_valid;
   logic            f_ready;
   logic [16*N-1:0] f_re;
   logic [16*N-1:0] f_im;
   logic [3:0]      wr_idx;
   logic [7:0]      frame_cnt;

   always #5 clk = ~clk;

   fft16_input_loader #(.N(N), .PTS(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_re      (s_re),
      .s_im      (s_im),
      .f_valid   (f_valid),
      .f_ready   (f_ready),
      .f_re      (f_re),
      .f_im      (f_im),
      .wr_idx    (wr_idx),
      .frame_cnt (frame_cnt)
   );

   // Frame k-th sample = base + k*step (mod 2^N); cnt = frame_cnt expected
   // right after the frame's last sample is accepted.
   typedef struct {
      logic [N-1:0] re0;
      logic [N-1:0] im0;
      logic [N-1:0] re_step;
      logic [N-1:0] im_step;
      logic [7:0]   cnt;
   } frame_vec_t;

   frame_vec_t      vecs [6];

   int              errors = 0;
   int              checks = 0;
   logic [16*N-1:0] exp_re_q [$];
   logic [16*N-1:0] exp_im_q [$];
   logic [16*N-1:0] cur_re;
   logic [16*N-1:0] cur_im;
   int              cur_idx;
   int              hs_count;
   int              cycle;
   int              hs_cycle [$];
   logic [16*N-1:0] exp1_re, exp1_im, exp2_re, exp2_im;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [N-1:0] elem(input logic [N-1:0] b, input logic [N-1:0] s, input int k);
      return b + 16'(k) * s;
   endfunction

   function automatic logic [16*N-1:0] frame_re(input int v);
      logic [16*N-1:0] f;
      for (int k = 0; k < 16; k++) f[k*N +: N] = elem(vecs[v].re0, vecs[v].re_step, k);
      return f;
   endfunction

   function automatic logic [16*N-1:0] frame_im(input int v);
      logic [16*N-1:0] f;
      for (int k = 0; k < 16; k++) f[k*N +: N] = elem(vecs[v].im0, vecs[v].im_step, k);
      return f;
   endfunction

   // One clock cycle: observe handshakes at the falling edge, then step past
   // the rising edge so the caller sees post-edge state.
   task automatic tick();
      @(negedge clk);
      if (rst) begin
         exp_re_q.delete();
         exp_im_q.delete();
         cur_idx = 0;
      end else begin
         if (s_valid && s_ready) begin
            cur_re[cur_idx*N +: N] = s_re;
            cur_im[cur_idx*N +: N] = s_im;
            cur_idx++;
            if (cur_idx == 16) begin
               exp_re_q.push_back(cur_re);
               exp_im_q.push_back(cur_im);
               cur_idx = 0;
            end
         end
         if (f_valid && f_ready) begin
            hs_count++;
            hs_cycle.push_back(cycle);
            if (exp_re_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL hs_unexpected: hand-off with no expected frame at cycle %0d", cycle);
            end else begin
               chk("hs_frame_re", f_re, exp_re_q.pop_front());
               chk("hs_frame_im", f_im, exp_im_q.pop_front());
            end
         end
      end
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic drive_sample(input logic [N-1:0] re, input logic [N-1:0] im);
      s_valid = 1'b1;
      s_re    = re;
      s_im    = im;
      tick();
   endtask

   task automatic send_vec(input int v, input int first, input int last);
      for (int k = first; k <= last; k++) begin
         drive_sample(elem(vecs[v].re0, vecs[v].re_step, k), elem(vecs[v].im0, vecs[v].im_step, k));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'h7FF0, 16'h8000, 16'h0001, 16'h0001, 8'd0};
      vecs[1] = '{16'h8000, 16'h7FFF, 16'h1000, 16'hFFFF, 8'd1};
      vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 8'd2};
      vecs[3] = '{16'h1234, 16'hFEDC, 16'h1111, 16'h0F0F, 8'd3};
      vecs[4] = '{16'hA5A5, 16'h5A5A, 16'h0101, 16'hFEFF, 8'd4};
      vecs[5] = '{16'h0F00, 16'hC001, 16'h0033, 16'h0777, 8'd5};

      rst = 1'b1; s_valid = 1'b0; f_ready = 1'b0; s_re = '0; s_im = '0;
      cur_idx = 0; hs_count = 0; cycle = 0; cur_re = '0; cur_im = '0;

      // ---- reset state ----
      repeat (3) tick();
      chk("rst_f_valid",   256'(f_valid),   256'd0);
      chk("rst_wr_idx",    256'(wr_idx),    256'd0);
      chk("rst_frame_cnt", 256'(frame_cnt), 256'd0);
      chk("rst_f_re",      f_re,            256'd0);
      chk("rst_f_im",      f_im,            256'd0);
      rst = 1'b0;
      tick();
      chk("rst_s_ready",   256'(s_ready),   256'd1);

      // ---- frame 1: k / -k with f_ready low ----
      for (int k = 0; k < 16; k++) begin
         exp1_re[k*N +: N] = 16'(k);
         exp1_im[k*N +: N] = -(16'(k));
         drive_sample(16'(k), -(16'(k)));
         chk("t1_s_ready", 256'(s_ready), 256'd1);
         if (k < 15) chk("t1_f_valid_low", 256'(f_valid), 256'd0);
      end
      chk("t1_f_valid", 256'(f_valid), 256'd1);
      chk("t1_wr_idx",  256'(wr_idx),  256'd0);
      chk("t1_f_re",    f_re,          exp1_re);
      chk("t1_f_im",    f_im,          exp1_im);

      // ---- frame 2: 100+k, both banks become full ----
      for (int k = 0; k < 16; k++) begin
         exp2_re[k*N +: N] = 16'(100 + k);
         exp2_im[k*N +: N] = 16'h1000 + 16'(k);
         drive_sample(16'(100 + k), 16'h1000 + 16'(k));
      end
      chk("t2_s_ready_low", 256'(s_ready), 256'd0);
      chk("t2_f_re_held",   f_re,          exp1_re);
      drive_sample(16'h0ABC, 16'h0DEF);   // 33rd sample, must stall
      chk("t2_wr_idx_stall", 256'(wr_idx),  256'd0);
      chk("t2_s_ready_stall", 256'(s_ready), 256'd0);
      chk("t2_f_im_held",    f_im,          exp1_im);

      // ---- one-cycle f_ready pulse frees a bank ----
      f_ready = 1'b1;
      tick();
      f_ready = 1'b0;
      chk("t3_frame_cnt", 256'(frame_cnt), 256'd1);
      chk("t3_f_valid",   256'(f_valid),   256'd1);
      chk("t3_f_re",      f_re,            exp2_re);
      chk("t3_f_im",      f_im,            exp2_im);
      chk("t3_s_ready",   256'(s_ready),   256'd1);
      tick();                              // 33rd sample now accepted into slot 0
      chk("t3_wr_idx",    256'(wr_idx),    256'd1);

      // ---- reset with a held frame and 7 samples of a partial frame ----
      for (int i = 0; i < 6; i++) drive_sample(16'hDEAD, 16'hBEEF);
      chk("t5_wr_idx_pre", 256'(wr_idx), 256'd7);
      rst = 1'b1; s_valid = 1'b0;
      tick();
      chk("t5_f_valid",   256'(f_valid),   256'd0);
      chk("t5_wr_idx",    256'(wr_idx),    256'd0);
      chk("t5_frame_cnt", 256'(frame_cnt), 256'd0);
      chk("t5_f_re",      f_re,            256'd0);
      chk("t5_f_im",      f_im,            256'd0);
      rst = 1'b0;
      tick();
      chk("t5_s_ready",   256'(s_ready),   256'd1);

      // ---- back-to-back streaming of four table frames ----
      hs_count = 0;
      hs_cycle.delete();
      f_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         for (int k = 0; k < 16; k++) begin
            drive_sample(elem(vecs[v].re0, vecs[v].re_step, k), elem(vecs[v].im0, vecs[v].im_step, k));
            chk("t4_s_ready", 256'(s_ready), 256'd1);
         end
         chk("t4_frame_cnt_step", 256'(frame_cnt), 256'(vecs[v].cnt));
      end
      s_valid = 1'b0;
      for (int i = 0; i < 8 && hs_count < 4; i++) tick();
      chk("t4_hs_count",  256'(hs_count),  256'd4);
      chk("t4_frame_cnt", 256'(frame_cnt), 256'd4);
      if (hs_cycle.size() == 4) begin
         for (int i = 1; i < 4; i++) chk("t4_hs_spacing", 256'(hs_cycle[i] - hs_cycle[i-1]), 256'd16);
      end

      // ---- same-cycle swap: 16th accept aligned with hand-off ----
      hs_count = 0;
      f_ready  = 1'b0;
      send_vec(4, 0, 15);
      chk("t6_f_valid_held", 256'(f_valid),   256'd1);
      chk("t6_cnt_held",     256'(frame_cnt), 256'(vecs[4].cnt));
      send_vec(5, 0, 14);
      f_ready = 1'b1;
      send_vec(5, 15, 15);
      f_ready = 1'b0;
      s_valid = 1'b0;
      chk("t6_f_valid_swap", 256'(f_valid),   256'd1);
      chk("t6_cnt_swap",     256'(frame_cnt), 256'(vecs[5].cnt));
      chk("t6_f_re_swap",    f_re,            frame_re(5));
      chk("t6_f_im_swap",    f_im,            frame_im(5));
      chk("t6_wr_idx",       256'(wr_idx),    256'd0);
      chk("t6_s_ready",      256'(s_ready),   256'd1);
      tick();
      chk("t6_cnt_stable",   256'(frame_cnt), 256'd5);
      f_ready = 1'b1;
      tick();
      f_ready = 1'b0;
      chk("t6_cnt_final",    256'(frame_cnt), 256'd6);
      chk("t6_f_valid_low",  256'(f_valid),   256'd0);
      chk("t6_hs_count",     256'(hs_count),  256'd2);
      chk("t6_queue_empty",  256'(exp_re_q.size()), 256'd0);
      chk("t6_no_partial",   256'(cur_idx),   256'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
